pcie_arbiter: RTL and testbench
===============================

Name: pcie_arbiter

Overview:
Round-robin bus arbiter for CHANNELS request/grant pairs on a shared PCI-style bus. It grants at most one requester at a time with a one-hot registered grant. It holds the grant while that master's transaction is in progress, signalled by pci_frame. When the transaction ends, it releases the bus and rotates priority to the channel after the last owner. It sits between the bus masters and the shared bus fabric.

Parameters:
CHANNELS, 8, number of requesting masters; width of pci_req and pci_grnt (must be at least 2).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
pci_req  input  CHANNELS  per-channel bus request, active-high, level-sensitive.
pci_frame  input  1  bus-busy indicator, active-high; the granted master drives it high for the duration of its transaction.
pci_grnt  output  CHANNELS  per-channel grant, active-high, one-hot or all-zero, registered.

Behaviour:
- Reset (rst high at a clk edge):
  - pci_grnt = 0.
  - State = IDLE.
  - Priority pointer = 0.
  - rst overrides everything, including mid-transaction; any active grant is dropped on the next edge.
- Priority pointer (ptr, log2(CHANNELS) bits):
  - Search order is ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1.
  - The first channel in that order with pci_req set wins.
- State IDLE:
  - pci_grnt = 0.
  - If any pci_req bit is set at an edge, the winner's grant bit is registered and state goes to GRANT.
  - Grant appears one cycle after the request is sampled.
  - If no request is set, stay in IDLE.
  - pci_frame is ignored in IDLE.
- State GRANT (grant issued, waiting for the master to start):
  - The grant is held.
  - pci_frame sampled high: go to BUSY, grant unchanged.
  - Granted pci_req sampled low while pci_frame is low: withdraw the grant (pci_grnt = 0), go to IDLE, ptr unchanged.
  - Otherwise remain in GRANT indefinitely; there is no timeout.
- State BUSY (transaction in progress):
  - The grant is held regardless of pci_req changes, on any channel including the owner.
  - pci_frame sampled low: pci_grnt = 0, ptr = (owner index + 1) mod CHANNELS, go to IDLE.
- Turnaround: at least one full cycle with pci_grnt = 0 between consecutive grants. No back-to-back handover.
- Invariants:
  - pci_grnt is never multi-hot.
  - pci_grnt changes only on clk edges.
  - A grant only goes to a channel whose pci_req was high at the sampling edge.
- Wrap-around: owner CHANNELS-1 sets ptr = 0.
- Simultaneous events:
  - New requests arriving during GRANT or BUSY have no effect until IDLE.
  - A request deasserting on the same edge that frame falls in BUSY has no extra effect.
- Implementation: FSM (IDLE/GRANT/BUSY), registered one-hot grant, registered owner index, rotating-priority encoder parameterised on CHANNELS.

Test Plan:
- Reset: hold rst high for 2 edges with pci_req=8'hFF and pci_frame=1 -> pci_grnt=8'h00 throughout and on the first edge after rst falls; ptr=0.
- Basic grant: after reset apply pci_req=8'b10010000 -> one cycle later pci_grnt=8'b00010000 (ch4). Hold 4 cycles with pci_frame=0 -> grant stays 8'b00010000 (GRANT state).
- Transaction and rotation:
  - Raise pci_frame for 4 cycles -> grant held.
  - Drop pci_frame and set pci_req=8'b00010100 -> next edge pci_grnt=8'h00 and ptr=5.
  - Following edge -> pci_grnt=8'b00000100 (ch2 wins via wrap-around over ch4).
- Grant withdrawal: in GRANT to ch2, drop pci_req[2] with pci_frame=0 -> pci_grnt=8'h00 next edge; the next arbitration uses the unchanged ptr.
- Fairness: pci_req=8'hFF held; each transaction is frame high 2 cycles then low -> grants cycle ch0,ch1,...,ch7,ch0, each separated by one zero-grant cycle.
- BUSY immunity and reset mid-transaction: in BUSY, change pci_req to 8'h00 -> grant held until frame falls. Assert rst while in BUSY -> pci_grnt=8'h00 next edge, ptr=0.

Source files
------------

// File: rtl/pcie_arbiter_if.sv
// Request/frame/grant bundle between PCI bus masters and the round-robin arbiter.
// Masters drive request and frame; the arbiter returns a one-hot grant.
interface pcie_arbiter_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] pci_req;
  logic                pci_frame;
  logic [CHANNELS-1:0] pci_grnt;

  modport master (output pci_req, output pci_frame, input pci_grnt);
  modport slave  (input pci_req, input pci_frame, output pci_grnt);
endinterface

// File: rtl/pcie_arbiter.sv
// Round-robin PCI bus arbiter: one-hot registered grant, held through the frame, priority rotates past the owner.
// Latency: grant one cycle after request is sampled; no backpressure, a grant stays until frame ends or the request drops.
module pcie_arbiter #(
  parameter int CHANNELS = 8
) (
  input  logic           clk,
  input  logic           rst,
  pcie_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] grnt_q, grnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    win_idx;
  logic                win_vld;
  int                  idx;

  // Rotating-priority search: ptr, ptr+1, ..., wrapping past CHANNELS-1 to 0.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!win_vld && bus.pci_req[idx]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grnt_d  = grnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        grnt_d = '0;
        if (win_vld) begin
          grnt_d          = '0;
          grnt_d[win_idx] = 1'b1;
          owner_d         = win_idx;
          state_d         = GRANT;
        end
      end
      GRANT: begin
        // Frame wins over a simultaneous request drop: the master has already started.
        if (bus.pci_frame) begin
          state_d = BUSY;
        end else if (!bus.pci_req[owner_q]) begin
          grnt_d  = '0;
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!bus.pci_frame) begin
          grnt_d  = '0;
          ptr_d   = (owner_q == PTR_W'(CHANNELS - 1)) ? '0 : owner_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        grnt_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grnt_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grnt_q  <= grnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign bus.pci_grnt = grnt_q;
endmodule

// File: tb/tb_pcie_arbiter.sv
// Scoreboarded bench for pcie_arbiter: directed walk through the arbitration scenarios, then random traffic.
// Expected grants come from a transaction-level model of the bus ownership rules.
module tb_pcie_arbiter;
  localparam int CH = 8;

  logic clk;
  logic rst;

  pcie_arbiter_if #(.CHANNELS(CH)) bus ();

  pcie_arbiter #(.CHANNELS(CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] grnt;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model of bus ownership: owner < 0 means the bus is free.
  int m_owner = -1;
  bit m_started = 1'b0;
  int m_ptr = 0;

  function automatic logic [CH-1:0] model_step(logic [CH-1:0] req, logic frame, logic r);
    logic [CH-1:0] g;
    if (r) begin
      m_owner   = -1;
      m_started = 1'b0;
      m_ptr     = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < CH; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % CH]) begin
          m_owner = (m_ptr + k) % CH;
        end
      end
      m_started = 1'b0;
    end else if (!m_started) begin
      if (frame) m_started = 1'b1;
      else if (!req[m_owner]) m_owner = -1;
    end else if (!frame) begin
      m_ptr     = (m_owner + 1) % CH;
      m_owner   = -1;
      m_started = 1'b0;
    end
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic step(input logic [CH-1:0] req, input logic frame, input logic r, input string name);
    exp_t e;
    @(negedge clk);
    bus.pci_req   = req;
    bus.pci_frame = frame;
    rst           = r;
    e.grnt = model_step(req, frame, r);
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected grant per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.pci_grnt !== e.grnt) begin
          errors++;
          $display("FAIL %s: pci_grnt=%b expected=%b at %0t", e.name, bus.pci_grnt, e.grnt, $time);
        end
        checks++;
        if (!$onehot0(bus.pci_grnt)) begin
          errors++;
          $display("FAIL onehot: pci_grnt=%b is multi-hot at %0t", bus.pci_grnt, $time);
        end
      end
    end
  end

  initial begin
    logic [CH-1:0] rq;
    logic          fr;
    logic          rr;
    bus.pci_req   = '0;
    bus.pci_frame = 1'b0;
    rst           = 1'b1;

    step(8'hFF, 1'b1, 1'b1, "reset");
    step(8'hFF, 1'b1, 1'b1, "reset");
    step(8'h00, 1'b0, 1'b0, "reset_release");

    step(8'b1001_0000, 1'b0, 1'b0, "basic_grant");
    repeat (4) step(8'b1001_0000, 1'b0, 1'b0, "grant_hold");
    repeat (4) step(8'b1001_0000, 1'b1, 1'b0, "busy_hold");
    step(8'b0001_0100, 1'b0, 1'b0, "release");
    step(8'b0001_0100, 1'b0, 1'b0, "wrap_grant");

    step(8'b0001_0000, 1'b0, 1'b0, "withdraw");
    step(8'b0100_0001, 1'b0, 1'b0, "ptr_kept");
    step(8'b0100_0001, 1'b1, 1'b0, "ptr_kept_busy");
    step(8'b0100_0001, 1'b0, 1'b0, "ptr_kept_release");

    for (int t = 0; t < 9; t++) begin
      step(8'hFF, 1'b0, 1'b0, "fair_grant");
      step(8'hFF, 1'b1, 1'b0, "fair_busy");
      step(8'hFF, 1'b1, 1'b0, "fair_busy");
      step(8'hFF, 1'b0, 1'b0, "fair_gap");
    end

    step(8'b0000_1000, 1'b0, 1'b0, "imm_grant");
    step(8'b0000_1000, 1'b1, 1'b0, "imm_busy");
    repeat (3) step(8'h00, 1'b1, 1'b0, "busy_immune");
    step(8'hFF, 1'b1, 1'b0, "busy_immune");
    step(8'hFF, 1'b1, 1'b1, "reset_mid_txn");
    step(8'b1000_0001, 1'b0, 1'b0, "reset_ptr_zero");
    step(8'b1000_0001, 1'b0, 1'b1, "reset_mid_grant");

    for (int t = 0; t < 3000; t++) begin
      rq = CH'($urandom);
      if ($urandom_range(0, 2) == 0) rq = rq & CH'($urandom);
      fr = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 99) == 0);
      step(rq, fr, rr, "random");
    end

    step(8'h00, 1'b0, 1'b0, "drain");
    step(8'h00, 1'b0, 1'b0, "drain");
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected grants left unchecked, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
